// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter with an in-order tag FIFO that routes each response to its issuer.
// Optional MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no round-robin state).
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               r0_valid,
  input  logic [ADDR_W-1:0]                  r0_addr,
  output logic                               r0_ready,
  output logic                               r0_rsp_valid,
  output logic                               r0_rsp_error,
  output logic [DATA_W-1:0]                  r0_rsp_data,
  input  logic                               r1_valid,
  input  logic [ADDR_W-1:0]                  r1_addr,
  output logic                               r1_ready,
  output logic                               r1_rsp_valid,
  output logic                               r1_rsp_error,
  output logic [DATA_W-1:0]                  r1_rsp_data,
  output logic                               m_valid,
  output logic [ADDR_W-1:0]                  m_addr,
  input  logic                               m_ready,
  input  logic                               m_rsp_valid,
  input  logic                               m_rsp_error,
  input  logic [DATA_W-1:0]                  m_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               spurious_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;

  req_id_e       tag_q [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          spur_q, spur_d;
  req_id_e       gnt, tie_pref;
  logic          full, empty, can_push, push, pop;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign tie_pref = REQ0;
`else
  // rr_q holds the tie winner for the next cycle, i.e. the requester not granted last.
  req_id_e rr_q, rr_d;
  assign tie_pref = rr_q;
`endif

  always_comb begin
    full     = (count_q == CW'(MAX_OUTSTANDING));
    empty    = (count_q == '0);
    can_push = !full || m_rsp_valid;

    if (r0_valid && r1_valid) gnt = tie_pref;
    else if (r1_valid)        gnt = REQ1;
    else                      gnt = REQ0;

    m_valid  = (r0_valid || r1_valid) && can_push;
    m_addr   = (gnt == REQ1) ? r1_addr : r0_addr;
    r0_ready = r0_valid && (gnt == REQ0) && m_ready && can_push;
    r1_ready = r1_valid && (gnt == REQ1) && m_ready && can_push;
    push     = m_valid && m_ready;

    // A response against an empty FIFO is spurious even if a tag is pushed this cycle.
    pop          = m_rsp_valid && !empty;
    r0_rsp_valid = pop && (tag_q[rd_ptr_q] == REQ0);
    r1_rsp_valid = pop && (tag_q[rd_ptr_q] == REQ1);
    r0_rsp_error = m_rsp_error;
    r1_rsp_error = m_rsp_error;
    r0_rsp_data  = m_rsp_data;
    r1_rsp_data  = m_rsp_data;

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    spur_d   = spur_q || (m_rsp_valid && empty);
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_d = rr_q;
    if (push) rr_d = (gnt == REQ0) ? REQ1 : REQ0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      spur_q   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q     <= REQ0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      spur_q   <= spur_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Tag storage needs no reset: entries are only read while the occupancy count covers them.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= gnt;
  end

  assign outstanding  = count_q;
  assign spurious_err = spur_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_port_arbiter;
  localparam int MAXO = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = $clog2(MAXO) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r1_valid, m_ready, m_rsp_valid, m_rsp_error;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] m_rsp_data;
  logic          r0_ready, r0_rsp_valid, r0_rsp_error, r1_ready, r1_rsp_valid, r1_rsp_error;
  logic [DW-1:0] r0_rsp_data, r1_rsp_data;
  logic          m_valid, spurious_err;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] outstanding;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_error(r0_rsp_error), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_error(r1_rsp_error), .r1_rsp_data(r1_rsp_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_ready(m_ready),
    .m_rsp_valid(m_rsp_valid), .m_rsp_error(m_rsp_error), .m_rsp_data(m_rsp_data),
    .outstanding(outstanding), .spurious_err(spurious_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of issuing requester ids, last granted id (-1 = none since reset), sticky flag.
  int tagq[$];
  int last_gnt = -1;
  bit spur_m   = 1'b0;
  int e_gnt;
  bit e_m_valid, e_r0_ready, e_r1_ready, e_r0_rsp, e_r1_rsp;
  logic [AW-1:0] e_m_addr;

  function automatic void model_eval();
    bit canp;
    canp  = (tagq.size() < MAXO) || m_rsp_valid;
    e_gnt = -1;
    if (r0_valid && r1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      e_gnt = 0;
`else
      e_gnt = (last_gnt == 0) ? 1 : 0;
`endif
    end else if (r0_valid) e_gnt = 0;
    else if (r1_valid)     e_gnt = 1;
    e_m_valid  = (e_gnt >= 0) && canp;
    e_m_addr   = (e_gnt == 1) ? r1_addr : r0_addr;
    e_r0_ready = (e_gnt == 0) && m_ready && canp;
    e_r1_ready = (e_gnt == 1) && m_ready && canp;
    e_r0_rsp   = m_rsp_valid && (tagq.size() > 0) && (tagq[0] == 0);
    e_r1_rsp   = m_rsp_valid && (tagq.size() > 0) && (tagq[0] == 1);
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      tagq.delete();
      last_gnt = -1;
      spur_m   = 1'b0;
    end else begin
      if (m_rsp_valid) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else spur_m = 1'b1;
      end
      if (e_m_valid && m_ready) begin
        tagq.push_back(e_gnt);
        last_gnt = e_gnt;
      end
    end
    #1;
  endtask

  task automatic idle();
    r0_valid = 0; r1_valid = 0; r0_addr = '0; r1_addr = '0;
    m_ready = 0; m_rsp_valid = 0; m_rsp_error = 0; m_rsp_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    tests++; if (outstanding !== '0) begin fails++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    tests++; if (spurious_err !== 1'b0) begin fails++; $display("FAIL reset_spurious got=%b exp=0", spurious_err); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    tests++; if (m_addr !== r0_addr) begin fails++; $display("FAIL reset_idle_addr got=%h exp=%h", m_addr, r0_addr); end
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      r0_valid    = (i < 3);
      r0_addr     = 32'(4 * i);
      m_rsp_valid = (tagq.size() > 0);
      m_rsp_data  = 32'h13;
      #1;
      if (i < 3) begin
        tests++; if (r0_ready !== 1'b1) begin fails++; $display("FAIL single_ready[%0d] got=%b exp=1", i, r0_ready); end
        tests++; if (m_addr !== 32'(4 * i)) begin fails++; $display("FAIL single_addr[%0d] got=%h exp=%h", i, m_addr, 4 * i); end
      end
      tests++; if (r0_rsp_valid !== (i >= 1 && i <= 3)) begin fails++; $display("FAIL single_rsp[%0d] got=%b exp=%b", i, r0_rsp_valid, (i >= 1 && i <= 3)); end
      if (i >= 1 && i <= 3) begin
        tests++; if (r0_rsp_data !== 32'h13) begin fails++; $display("FAIL single_data[%0d] got=%h exp=13", i, r0_rsp_data); end
      end
      tests++; if (r1_rsp_valid !== 1'b0) begin fails++; $display("FAIL single_r1_rsp[%0d] got=%b exp=0", i, r1_rsp_valid); end
      tests++; if (outstanding !== CW'(i >= 1 && i <= 3)) begin fails++; $display("FAIL single_outstanding[%0d] got=%0d exp=%0d", i, outstanding, (i >= 1 && i <= 3)); end
      tick();
    end
    idle();
  endtask

  task automatic test_contention();
    int exp_g[4];
    do_reset();
    m_ready = 1;
    r0_addr = 32'h1000;
    r1_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g[i] = 0;
`else
      exp_g[i] = i % 2;
`endif
    end
    for (int i = 0; i < 5; i++) begin
      r0_valid    = (i < 4);
      r1_valid    = (i < 4);
      m_rsp_valid = (tagq.size() > 0);
      m_rsp_data  = 32'(i);
      #1;
      if (i < 4) begin
        tests++; if (r0_ready !== (exp_g[i] == 0)) begin fails++; $display("FAIL cont_r0_ready[%0d] got=%b exp=%b", i, r0_ready, exp_g[i] == 0); end
        tests++; if (r1_ready !== (exp_g[i] == 1)) begin fails++; $display("FAIL cont_r1_ready[%0d] got=%b exp=%b", i, r1_ready, exp_g[i] == 1); end
        tests++; if (m_addr !== ((exp_g[i] == 1) ? 32'h2000 : 32'h1000)) begin fails++; $display("FAIL cont_addr[%0d] got=%h", i, m_addr); end
      end
      if (i >= 1) begin
        tests++; if (r0_rsp_valid !== (exp_g[i-1] == 0)) begin fails++; $display("FAIL cont_r0_rsp[%0d] got=%b exp=%b", i, r0_rsp_valid, exp_g[i-1] == 0); end
        tests++; if (r1_rsp_valid !== (exp_g[i-1] == 1)) begin fails++; $display("FAIL cont_r1_rsp[%0d] got=%b exp=%b", i, r1_rsp_valid, exp_g[i-1] == 1); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    m_ready  = 1;
    r1_valid = 1;
    r1_addr  = 32'h40;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++; if (r1_ready !== (i < MAXO)) begin fails++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, r1_ready, i < MAXO); end
      tests++; if (m_valid !== (i < MAXO)) begin fails++; $display("FAIL full_m_valid[%0d] got=%b exp=%b", i, m_valid, i < MAXO); end
      tests++; if (outstanding !== CW'((i < MAXO) ? i : MAXO)) begin fails++; $display("FAIL full_outstanding[%0d] got=%0d", i, outstanding); end
      tick();
    end
    m_rsp_valid = 1;
    m_rsp_data  = 32'hABCD;
    #1;
    tests++; if (r1_ready !== 1'b1) begin fails++; $display("FAIL full_pushpop_ready got=%b exp=1", r1_ready); end
    tests++; if (r1_rsp_valid !== 1'b1) begin fails++; $display("FAIL full_pushpop_rsp got=%b exp=1", r1_rsp_valid); end
    tick();
    m_rsp_valid = 0;
    r1_valid    = 0;
    #1;
    tests++; if (outstanding !== CW'(MAXO)) begin fails++; $display("FAIL full_after_pushpop got=%0d exp=%0d", outstanding, MAXO); end
    idle();
  endtask

  task automatic test_error();
    do_reset();
    m_ready  = 1;
    r1_valid = 1; tick();
    r1_valid = 0; r0_valid = 1; tick();
    r0_valid = 0;
    m_rsp_valid = 1; m_rsp_error = 1; m_rsp_data = 32'hDEAD;
    #1;
    tests++; if (r1_rsp_valid !== 1'b1 || r1_rsp_error !== 1'b1) begin fails++; $display("FAIL err_first_r1 got=%b/%b exp=1/1", r1_rsp_valid, r1_rsp_error); end
    tests++; if (r0_rsp_valid !== 1'b0) begin fails++; $display("FAIL err_first_r0 got=%b exp=0", r0_rsp_valid); end
    tests++; if (r1_rsp_data !== 32'hDEAD) begin fails++; $display("FAIL err_first_data got=%h exp=dead", r1_rsp_data); end
    tick();
    m_rsp_error = 0; m_rsp_data = 32'hBEEF;
    #1;
    tests++; if (r0_rsp_valid !== 1'b1 || r0_rsp_error !== 1'b0) begin fails++; $display("FAIL err_second_r0 got=%b/%b exp=1/0", r0_rsp_valid, r0_rsp_error); end
    tests++; if (r1_rsp_valid !== 1'b0) begin fails++; $display("FAIL err_second_r1 got=%b exp=0", r1_rsp_valid); end
    tick();
    idle();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    m_ready  = 1;
    r0_valid = 1; tick(); tick();
    r0_valid = 0;
    #1;
    tests++; if (outstanding !== CW'(2)) begin fails++; $display("FAIL spur_pre_outstanding got=%0d exp=2", outstanding); end
    rst = 1; tick(); rst = 0;
    #1;
    tests++; if (spurious_err !== 1'b0) begin fails++; $display("FAIL spur_pre_flag got=%b exp=0", spurious_err); end
    for (int k = 0; k < 2; k++) begin
      m_rsp_valid = 1;
      #1;
      tests++; if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin fails++; $display("FAIL spur_rsp[%0d] got=%b%b exp=00", k, r0_rsp_valid, r1_rsp_valid); end
      tick();
      m_rsp_valid = 0;
      #1;
      tests++; if (spurious_err !== 1'b1) begin fails++; $display("FAIL spur_flag[%0d] got=%b exp=1", k, spurious_err); end
      tests++; if (outstanding !== '0) begin fails++; $display("FAIL spur_outstanding[%0d] got=%0d exp=0", k, outstanding); end
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r0_valid    = $urandom_range(0, 1);
      r1_valid    = $urandom_range(0, 1);
      r0_addr     = $urandom;
      r1_addr     = $urandom;
      m_ready     = ($urandom_range(0, 3) != 0);
      m_rsp_valid = (tagq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      m_rsp_error = $urandom_range(0, 1);
      m_rsp_data  = $urandom;
      #1;
      model_eval();
      tests++; if (m_valid !== e_m_valid) begin fails++; $display("FAIL rnd_m_valid[%0d] got=%b exp=%b", c, m_valid, e_m_valid); end
      if (e_m_valid) begin
        tests++; if (m_addr !== e_m_addr) begin fails++; $display("FAIL rnd_m_addr[%0d] got=%h exp=%h", c, m_addr, e_m_addr); end
      end
      tests++; if (r0_ready !== e_r0_ready || r1_ready !== e_r1_ready) begin fails++; $display("FAIL rnd_ready[%0d] got=%b%b exp=%b%b", c, r0_ready, r1_ready, e_r0_ready, e_r1_ready); end
      tests++; if (r0_rsp_valid !== e_r0_rsp || r1_rsp_valid !== e_r1_rsp) begin fails++; $display("FAIL rnd_rsp[%0d] got=%b%b exp=%b%b", c, r0_rsp_valid, r1_rsp_valid, e_r0_rsp, e_r1_rsp); end
      tests++; if (r0_rsp_data !== m_rsp_data || r1_rsp_error !== m_rsp_error) begin fails++; $display("FAIL rnd_passthru[%0d] got=%h/%b exp=%h/%b", c, r0_rsp_data, r1_rsp_error, m_rsp_data, m_rsp_error); end
      tests++; if (outstanding !== CW'(tagq.size())) begin fails++; $display("FAIL rnd_outstanding[%0d] got=%0d exp=%0d", c, outstanding, tagq.size()); end
      tests++; if (spurious_err !== spur_m) begin fails++; $display("FAIL rnd_spurious[%0d] got=%b exp=%b", c, spurious_err, spur_m); end
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_error();
    test_spurious_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
